// File: rtl/alu_share_sched_pkg.sv
// rtl/alu_share_sched_pkg.sv - shared types and defaults for the ALU sharing scheduler
package alu_share_sched_pkg;

  localparam int ALU_DATA_W = 4;
  localparam int ALU_OP_W   = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOR = 3'd5,
    OP_SLT = 3'd6,
    OP_SLL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_e;

  function automatic int rr_next(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/alu_share_sched_if.sv
// rtl/alu_share_sched_if.sv - request/response channels between clients and the scheduler
interface alu_share_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int OP_W    = 3
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ-1:0]        resp_ready;
  logic [DATA_W-1:0]         resp_data;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/alu_share_sched_rr_arbiter.sv
// rtl/alu_share_sched_rr_arbiter.sv - combinational round-robin pick starting at the pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    id_o
);

  always_comb begin
    int   idx;
    logic found;
    grant_o = '0;
    id_o    = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_i) + i) % NUM_REQ;
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        id_o         = ID_W'(idx);
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_sched.sv
// rtl/alu_share_sched.sv - round-robin scheduler sharing one ALU among NUM_REQ requesters
module alu_share_sched
  import alu_share_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = ALU_DATA_W,
  parameter int OP_W    = ALU_OP_W,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  alu_share_sched_if.slave  bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_c,
  output logic              busy,
  output logic [ID_W-1:0]   grant_id,
  output logic [CNT_W-1:0]  done_cnt
);

  localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

  sched_state_e       state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    grant_q;
  logic [DATA_W-1:0]  a_q, b_q, res_q;
  logic [OP_W-1:0]    op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] win_oh;
  logic [ID_W-1:0]    win_id;
  logic               req_hs, resp_hs, last_wait;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (win_oh),
    .id_o    (win_id)
  );

  assign req_hs    = (state_q == S_IDLE) && (|bus.req_valid);
  assign resp_hs   = (state_q == S_RESP) && bus.resp_ready[grant_q];
  assign last_wait = (state_q == S_WAIT) && (lat_q == LAT_W'(1));
  assign ptr_d     = ID_W'(rr_next(int'(win_id), NUM_REQ));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE:  if (req_hs) state_d = S_ISSUE;
      S_ISSUE: begin
        state_d = S_WAIT;
        lat_d   = LAT_W'(ALU_LAT);
      end
      S_WAIT: begin
        if (lat_q == LAT_W'(1)) state_d = S_RESP;
        else                    lat_d   = lat_q - 1'b1;
      end
      S_RESP:  if (resp_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == S_IDLE) ? win_oh : '0;
    bus.resp_valid = (state_q == S_RESP) ? (NUM_REQ'(1) << grant_q) : '0;
    busy           = (state_q != S_IDLE);
  end

  // Operands stay frozen from one request handshake to the next so the ALU sees stable inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (req_hs) begin
        a_q     <= bus.req_a[win_id*DATA_W +: DATA_W];
        b_q     <= bus.req_b[win_id*DATA_W +: DATA_W];
        op_q    <= bus.req_op[win_id*OP_W +: OP_W];
        grant_q <= win_id;
        ptr_q   <= ptr_d;
      end
      if (last_wait) res_q <= alu_c;
      if (resp_hs)   cnt_q <= cnt_q + 1'b1;
    end
  end

  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_op        = op_q;
  assign bus.resp_data = res_q;
  assign grant_id      = grant_q;
  assign done_cnt      = cnt_q;

endmodule

// File: tb/tb_alu_share_sched.sv
// tb/tb_alu_share_sched.sv - scoreboard bench for alu_share_sched with default and slow-ALU instances
module tb_alu_share_sched;
  import alu_share_sched_pkg::*;

  localparam int NR = 4;
  localparam int DW = 4;
  localparam int OW = 3;

  typedef struct {
    int         id;
    logic [3:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_share_sched_if #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW)) bus ();
  alu_share_sched_if #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW)) bus6 ();

  logic [DW-1:0] alu_a, alu_b, alu_c, alu_a6, alu_b6, alu_c6;
  logic [OW-1:0] alu_op, alu_op6;
  logic          busy, busy6;
  logic [1:0]    grant_id, grant_id6;
  logic [15:0]   done_cnt;
  logic [3:0]    done_cnt6;

  alu_share_sched #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW), .ALU_LAT(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .busy(busy), .grant_id(grant_id), .done_cnt(done_cnt)
  );

  alu_share_sched #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW), .ALU_LAT(3), .CNT_W(4)) dut6 (
    .clk(clk), .reset(reset), .bus(bus6),
    .alu_a(alu_a6), .alu_b(alu_b6), .alu_op(alu_op6), .alu_c(alu_c6),
    .busy(busy6), .grant_id(grant_id6), .done_cnt(done_cnt6)
  );

  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~(a | b);
      3'd6:    return ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
      default: return a << b;
    endcase
  endfunction

  function automatic int oh_idx(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = NR - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // ALU models: one register stage for the default DUT, three for the slow one
  logic [3:0] pipe1;
  logic [3:0] pipe6 [3];
  always @(posedge clk) begin
    pipe1    <= alu_f(alu_a, alu_b, alu_op);
    pipe6[0] <= alu_f(alu_a6, alu_b6, alu_op6);
    pipe6[1] <= pipe6[0];
    pipe6[2] <= pipe6[1];
  end
  assign alu_c  = pipe1;
  assign alu_c6 = pipe6[2];

  exp_t sb[$];
  exp_t sb6[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin : mon
    int   w;
    exp_t e;
    if (reset === 1'b0) begin
      if (|(bus.req_valid & bus.req_ready)) begin
        w = oh_idx(bus.req_ready);
        sb.push_back('{w, alu_f(bus.req_a[w*DW +: DW], bus.req_b[w*DW +: DW], bus.req_op[w*OW +: OW])});
      end
      if (|(bus.resp_valid & bus.resp_ready)) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: got valid %b data %h, required no response", bus.resp_valid, bus.resp_data);
        end else begin
          e = sb.pop_front();
          if (bus.resp_valid !== (4'b1 << e.id) || bus.resp_data !== e.data) begin
            errors++;
            $display("FAIL resp_sb: got valid %b data %h, required valid %b data %h",
                     bus.resp_valid, bus.resp_data, 4'b1 << e.id, e.data);
          end
        end
      end
    end
  end

  always @(negedge clk) begin : mon6
    int   w;
    exp_t e;
    if (reset === 1'b0) begin
      if (|(bus6.req_valid & bus6.req_ready)) begin
        w = oh_idx(bus6.req_ready);
        sb6.push_back('{w, alu_f(bus6.req_a[w*DW +: DW], bus6.req_b[w*DW +: DW], bus6.req_op[w*OW +: OW])});
      end
      if (|(bus6.resp_valid & bus6.resp_ready)) begin
        checks++;
        if (sb6.size() == 0) begin
          errors++;
          $display("FAIL resp6_unexpected: got valid %b data %h, required no response", bus6.resp_valid, bus6.resp_data);
        end else begin
          e = sb6.pop_front();
          if (bus6.resp_valid !== (4'b1 << e.id) || bus6.resp_data !== e.data) begin
            errors++;
            $display("FAIL resp6_sb: got valid %b data %h, required valid %b data %h",
                     bus6.resp_valid, bus6.resp_data, 4'b1 << e.id, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    bus.req_a[id*DW +: DW]  = a;
    bus.req_b[id*DW +: DW]  = b;
    bus.req_op[id*OW +: OW] = op;
  endtask

  task automatic wait_req_hs(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (|(bus.req_valid & bus.req_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.resp_valid !== 4'b0) begin
      errors++;
      $display("FAIL reset_state: got busy %b resp_valid %b, required 0 0000", busy, bus.resp_valid);
    end
    checks++;
    if (alu_a !== 4'h0 || alu_b !== 4'h0 || alu_op !== 3'h0 || bus.resp_data !== 4'h0) begin
      errors++;
      $display("FAIL reset_regs: got a %h b %h op %h data %h, required all 0", alu_a, alu_b, alu_op, bus.resp_data);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0 || grant_id !== 2'd0 || done_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_idle: got req_ready %b grant %0d done %0d, required 0000 0 0",
               bus.req_ready, grant_id, done_cnt);
    end
  endtask

  task automatic test_single_op();
    int lat;
    tick();
    set_req(0, 4'd3, 4'd5, OP_ADD);
    bus.resp_ready = 4'b0;
    bus.req_valid  = 4'b0001;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready: got %b, required 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || alu_a !== 4'd3 || alu_b !== 4'd5 || alu_op !== OP_ADD || bus.resp_valid !== 4'b0) begin
      errors++;
      $display("FAIL single_issue: got busy %b a %h b %h op %h rv %b, required 1 3 5 0 0000",
               busy, alu_a, alu_b, alu_op, bus.resp_valid);
    end
    lat = 1;
    while (bus.resp_valid === 4'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 3 || bus.resp_valid !== 4'b0001 || bus.resp_data !== 4'd8) begin
      errors++;
      $display("FAIL single_latency: got lat %0d rv %b data %h, required 3 0001 8", lat, bus.resp_valid, bus.resp_data);
    end
    tick();
    bus.resp_ready = 4'b0001;
    @(negedge clk);
    tick();
    bus.resp_ready = 4'b0;
    @(negedge clk);
    checks++;
    if (done_cnt !== 16'd1 || busy !== 1'b0 || bus.resp_valid !== 4'b0) begin
      errors++;
      $display("FAIL single_done: got done %0d busy %b rv %b, required 1 0 0000", done_cnt, busy, bus.resp_valid);
    end
  endtask

  task automatic test_contention();
    int got[$];
    int exp_ids[6] = '{0, 1, 2, 3, 0, 2};
    int n;
    bit ok;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < NR; i++) set_req(i, 4'(i + 1), 4'(2 * i), 3'(i));
    bus.resp_ready = 4'b1111;
    bus.req_valid  = 4'b1111;
    n = 0;
    while (got.size() < 4 && n < 100) begin
      @(negedge clk);
      if (|(bus.req_valid & bus.req_ready)) got.push_back(oh_idx(bus.req_ready));
      n++;
      tick();
    end
    bus.req_valid = 4'b0101;
    n = 0;
    while (got.size() < 6 && n < 100) begin
      @(negedge clk);
      if (|(bus.req_valid & bus.req_ready)) got.push_back(oh_idx(bus.req_ready));
      n++;
      tick();
    end
    bus.req_valid = 4'b0;
    checks++;
    if (got.size() != 6) begin
      errors++;
      $display("FAIL contention_count: got %0d grants, required 6", got.size());
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      checks++;
      if (got[i] != exp_ids[i]) begin
        errors++;
        $display("FAIL contention_order[%0d]: got %0d, required %0d", i, got[i], exp_ids[i]);
      end
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL contention_drain: got busy %b pending %0d, required idle", busy, sb.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    tick();
    set_req(1, 4'd9, 4'd4, OP_SUB);
    bus.resp_ready = 4'b0;
    bus.req_valid  = 4'b0010;
    wait_req_hs(ok);
    bus.req_valid  = 4'b1101;
    bus.resp_ready = 4'b1101;
    n = 0;
    while (bus.resp_valid === 4'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (bus.resp_valid !== 4'b0010 || bus.resp_data !== 4'd5) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rv %b data %h, required 0010 5", c, bus.resp_valid, bus.resp_data);
      end
      checks++;
      if (bus.req_ready !== 4'b0 || busy !== 1'b1 || grant_id !== 2'd1) begin
        errors++;
        $display("FAIL bp_block[%0d]: got ready %b busy %b grant %0d, required 0000 1 1",
                 c, bus.req_ready, busy, grant_id);
      end
    end
    tick();
    bus.req_valid  = 4'b0;
    bus.resp_ready = 4'b1111;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_drain: got busy %b pending %0d, required idle", busy, sb.size());
    end
  endtask

  task automatic test_wrap_fwd();
    logic [3:0] ta [8] = '{4'hF, 4'h0, 4'h3, 4'hC, 4'hC, 4'hC, 4'h5, 4'hF};
    logic [3:0] tb_ [8] = '{4'h1, 4'h1, 4'h1, 4'hA, 4'hA, 4'hA, 4'h2, 4'h1};
    logic [2:0] top [8] = '{OP_ADD, OP_SUB, OP_SLL, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT};
    logic [3:0] tres [8] = '{4'h0, 4'hF, 4'h6, 4'h8, 4'hE, 4'h6, 4'h8, 4'h1};
    bit ok;
    int n;
    bus.resp_ready = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      set_req(3, ta[k], tb_[k], top[k]);
      bus.req_valid = 4'b1000;
      wait_req_hs(ok);
      bus.req_valid = 4'b0;
      @(negedge clk);
      checks++;
      if (!ok || alu_op !== top[k] || alu_a !== ta[k] || alu_b !== tb_[k]) begin
        errors++;
        $display("FAIL fwd[%0d]: got hs %0d a %h b %h op %h, required 1 %h %h %h",
                 k, ok, alu_a, alu_b, alu_op, ta[k], tb_[k], top[k]);
      end
      n = 0;
      while (bus.resp_valid === 4'b0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (bus.resp_valid !== 4'b1000 || bus.resp_data !== tres[k]) begin
        errors++;
        $display("FAIL result[%0d]: got rv %b data %h, required 1000 %h", k, bus.resp_valid, bus.resp_data, tres[k]);
      end
      wait_idle(ok);
    end
  endtask

  task automatic test_reset_wait();
    bit ok;
    int stray;
    tick();
    set_req(2, 4'd7, 4'd7, OP_ADD);
    bus.resp_ready = 4'b1111;
    bus.req_valid  = 4'b0100;
    wait_req_hs(ok);
    bus.req_valid = 4'b0;
    @(negedge clk);
    tick();
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got busy %b, required 1", busy);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.resp_valid !== 4'b0 || alu_a !== 4'd0 || grant_id !== 2'd0 ||
        done_cnt !== 16'd0 || bus.resp_data !== 4'd0) begin
      errors++;
      $display("FAIL rst_wait: got busy %b rv %b a %h grant %0d done %0d data %h, required all 0",
               busy, bus.resp_valid, alu_a, grant_id, done_cnt, bus.resp_data);
    end
    tick();
    set_req(0, 4'd2, 4'd2, OP_ADD);
    bus.req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_pointer: got ready %b, required 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.resp_valid[2] === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL rst_dropped: got %0d responses to requester 2, required 0", stray);
    end
    wait_idle(ok);
    checks++;
    if (!ok || done_cnt !== 16'd1) begin
      errors++;
      $display("FAIL rst_after: got idle %0d done %0d, required 1 1", ok, done_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    int lat;
    int n;
    bit hs;
    bus6.resp_ready = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      tick();
      bus6.req_a[(k%4)*DW +: DW]  = 4'(k);
      bus6.req_b[(k%4)*DW +: DW]  = 4'd1;
      bus6.req_op[(k%4)*OW +: OW] = OP_ADD;
      bus6.req_valid = 4'b1 << (k % 4);
      hs = 1'b0;
      for (int m = 0; m < 50 && !hs; m++) begin
        @(negedge clk);
        hs = |(bus6.req_valid & bus6.req_ready);
      end
      tick();
      bus6.req_valid = 4'b0;
      if (k == 0) begin
        lat = 1;
        @(negedge clk);
        while (bus6.resp_valid === 4'b0 && lat < 20) begin
          @(negedge clk);
          lat++;
        end
        checks++;
        if (!hs || lat != 5) begin
          errors++;
          $display("FAIL lat3_latency: got hs %0d lat %0d, required 1 5", hs, lat);
        end
      end
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (busy6 !== 1'b0 && n < 50);
      if (k == 14) begin
        checks++;
        if (done_cnt6 !== 4'd15) begin
          errors++;
          $display("FAIL cnt_15: got %0d, required 15", done_cnt6);
        end
      end
    end
    checks++;
    if (done_cnt6 !== 4'd0 || sb6.size() != 0) begin
      errors++;
      $display("FAIL cnt_wrap: got done %0d pending %0d, required 0 0", done_cnt6, sb6.size());
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.req_valid   = '0;
    bus.req_a       = '0;
    bus.req_b       = '0;
    bus.req_op      = '0;
    bus.resp_ready  = '0;
    bus6.req_valid  = '0;
    bus6.req_a      = '0;
    bus6.req_b      = '0;
    bus6.req_op     = '0;
    bus6.resp_ready = '0;
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_wrap_fwd();
    test_reset_wait();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
